// File: rtl/iter_pkg.sv
// rtl/iter_pkg.sv - shared state encoding and drain defaults for the iteration controller and FIR-side blocks
package iter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } iter_state_e;

  localparam int DRAIN_CYCLES_DEF = 4;
  localparam int DRAIN_CNT_W      = 8;

endpackage

// File: rtl/iter_controller.sv
// rtl/iter_controller.sv - sequences iterative reconstruction runs: feed, FIR drain gap, done pulse
module iter_controller
  import iter_pkg::*;
#(
  parameter int SAMPLE_W     = 16,
  parameter int ITER_W       = 8,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [ITER_W-1:0]   cfg_num_iters,
  input  logic [SAMPLE_W-1:0] cfg_sig_len,
  input  logic                lvl_gen_valid,
  input  logic                sigbuff_valid,
  input  logic                fir_ready,
  output logic                iter_input_mux,
  output logic                iter_input_enable,
  output logic                sigbuff_rewind,
  output logic                busy,
  output logic                done,
  output logic [ITER_W-1:0]   iter_idx
);

  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

  iter_state_e            state, nxt_state;
  logic [SAMPLE_W-1:0]    sample_cnt, nxt_sample_cnt;
  logic [DRAIN_CNT_W-1:0] drain_cnt, nxt_drain_cnt;
  logic [SAMPLE_W-1:0]    sig_len_q, nxt_sig_len;
  logic [ITER_W-1:0]      num_iters_q, nxt_num_iters;
  logic [ITER_W-1:0]      nxt_iter_idx;
  logic                   nxt_mux, nxt_enable, nxt_rewind, nxt_busy, nxt_done;
  logic                   accept;

  // A sample is consumed only when the FIR takes it and the selected source offers one.
  assign accept = iter_input_enable & fir_ready &
                  (iter_input_mux ? lvl_gen_valid : sigbuff_valid);

  // State, counters, latched config and every output are registered here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= ST_IDLE;
      sample_cnt        <= '0;
      drain_cnt         <= '0;
      sig_len_q         <= '0;
      num_iters_q       <= '0;
      iter_idx          <= '0;
      iter_input_mux    <= 1'b1;
      iter_input_enable <= 1'b0;
      sigbuff_rewind    <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      state             <= nxt_state;
      sample_cnt        <= nxt_sample_cnt;
      drain_cnt         <= nxt_drain_cnt;
      sig_len_q         <= nxt_sig_len;
      num_iters_q       <= nxt_num_iters;
      iter_idx          <= nxt_iter_idx;
      iter_input_mux    <= nxt_mux;
      iter_input_enable <= nxt_enable;
      sigbuff_rewind    <= nxt_rewind;
      busy              <= nxt_busy;
      done              <= nxt_done;
    end
  end

  // Next-state and next-output decode; outputs are the registered image of the next state.
  always_comb begin
    nxt_state      = state;
    nxt_sample_cnt = sample_cnt;
    nxt_drain_cnt  = drain_cnt;
    nxt_sig_len    = sig_len_q;
    nxt_num_iters  = num_iters_q;
    nxt_iter_idx   = iter_idx;
    nxt_mux        = iter_input_mux;
    nxt_enable     = iter_input_enable;
    nxt_rewind     = 1'b0;
    case (state)
      ST_IDLE: begin
        nxt_mux    = 1'b1;
        nxt_enable = 1'b0;
        // abort in the same cycle suppresses start
        if (start && !abort) begin
          if (cfg_num_iters != '0 && cfg_sig_len != '0) begin
            nxt_state      = ST_FEED;
            nxt_num_iters  = cfg_num_iters;
            nxt_sig_len    = cfg_sig_len;
            nxt_iter_idx   = '0;
            nxt_sample_cnt = '0;
            nxt_enable     = 1'b1;
          end else begin
            nxt_state = ST_DONE;
          end
        end
      end
      ST_FEED: begin
        if (abort) begin
          nxt_state  = ST_DONE;
          nxt_enable = 1'b0;
        end else if (accept) begin
          if (sample_cnt == sig_len_q - SAMPLE_W'(1)) begin
            nxt_state      = ST_DRAIN;
            nxt_enable     = 1'b0;
            nxt_sample_cnt = '0;
            nxt_drain_cnt  = '0;
          end else begin
            nxt_sample_cnt = sample_cnt + SAMPLE_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          nxt_state = ST_DONE;
        end else if (drain_cnt == DRAIN_LAST) begin
          if (iter_idx == num_iters_q - ITER_W'(1)) begin
            nxt_state = ST_DONE;
          end else begin
            // later iterations refine the buffered signal rather than the level generator
            nxt_state    = ST_FEED;
            nxt_iter_idx = iter_idx + ITER_W'(1);
            nxt_mux      = 1'b0;
            nxt_rewind   = 1'b1;
            nxt_enable   = 1'b1;
          end
        end else begin
          nxt_drain_cnt = drain_cnt + DRAIN_CNT_W'(1);
        end
      end
      ST_DONE: begin
        nxt_state  = ST_IDLE;
        nxt_mux    = 1'b1;
        nxt_enable = 1'b0;
      end
      default: begin
        nxt_state = ST_IDLE;
      end
    endcase
    nxt_busy = (nxt_state != ST_IDLE);
    nxt_done = (nxt_state == ST_DONE);
  end

endmodule
